pwm_dimmer: RTL and testbench
=============================

PWM_DIMMER -- requirements
Module: pwm_dimmer

Interface
REQ-001 Parameter N, default 8, is the PWM counter and duty width, matching the triangle sample width.
REQ-002 Parameter P, default 16, is the prescale width.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ena  input  1  run enable; when low the block SHALL freeze.
REQ-006 duty  input  N  requested on-count per period (the triangle generator output).
REQ-007 prescale  input  P  number of extra clk cycles per counter step; 0 means one step per clk.
REQ-008 pwm  output  1  modulated output, registered.
REQ-009 period_start  output  1  one-cycle strobe on the first step of each period.
REQ-010 step  output  1  one-cycle strobe per completed period, intended to drive the triangle generator ena.

Function
REQ-011 State machine: IDLE (not yet armed) and RUN; IDLE->RUN on the first clk with ena=1; RUN->IDLE only on rst.
REQ-012 On the IDLE->RUN edge, duty_sh<=duty, pre_sh<=prescale, pre_cnt<=0, cnt<=0, and period_start<=1.
REQ-013 In RUN with ena=1, tick is asserted when pre_cnt==pre_sh; on tick pre_cnt<=0, otherwise pre_cnt<=pre_cnt+1.
REQ-014 On tick, cnt<=cnt+1 modulo 2^N; the wrap from 2^N-1 to 0 is a period boundary.
REQ-015 At a period boundary, duty_sh<=duty and pre_sh<=prescale; mid-period changes to duty or prescale SHALL have no effect.
REQ-016 period_start SHALL be 1 for exactly the cycle after a boundary update (or the arming update) and 0 otherwise.
REQ-017 step SHALL be 1 for exactly one cycle coincident with period_start after a boundary; it SHALL NOT assert on arming.
REQ-018 pwm (registered) <= 1 iff state is RUN, ena=1 and next-cycle cnt < duty_sh, so pwm for count k is visible in the same cycle as cnt==k.
REQ-019 duty_sh=0 SHALL give pwm constantly 0; duty_sh=2^N-1 SHALL give (2^N-1)/2^N on-time (full-on is not reachable, by design).
REQ-020 Period length SHALL be exactly 2^N*(pre_sh+1) clk cycles while ena stays high.
REQ-021 ena=0 in RUN: pre_cnt, cnt, duty_sh and pre_sh hold; pwm<=0; period_start and step stay 0; on ena=1 counting resumes from the held values without re-arming.
REQ-022 ena=0 in IDLE: the block stays in IDLE with all outputs 0.
REQ-023 Comparison SHALL be unsigned on N bits; pre_cnt SHALL be P bits and never exceed pre_sh.

Reset
REQ-024 rst=1 SHALL force state=IDLE, pre_cnt=0, cnt=0, duty_sh=0, pre_sh=0, pwm=0, period_start=0 and step=0 on the next edge, overriding ena.
REQ-025 rst asserted mid-period SHALL abort the period with no step pulse, and the next ena=1 cycle SHALL re-arm per REQ-012.

Verification (N=4 unless noted)
REQ-026 rst, then ena=1, prescale=0, duty=5 -> period_start high 1 cycle after arming; pwm high for 5 then low for 11 of each 16-cycle period; step every 16 cycles, none at arming.
REQ-027 prescale=2, duty=8 -> period 48 cycles, pwm high for 24, step spacing 48.
REQ-028 duty changed 5->12 at cnt=3 -> current period keeps 5 high counts; next period has 12; prescale change mid-period likewise deferred.
REQ-029 duty=0 -> pwm never high; duty=15 -> pwm low only during cnt==15; step still periodic.
REQ-030 ena dropped for 7 cycles at cnt=9 -> pwm 0, counters frozen, no strobes; after resume the period completes with cnt continuing from 9 and total active length 16.
REQ-031 rst pulsed at cnt=10 with ena held high -> all outputs 0, no step; re-arm occurs on the first cycle after rst deasserts and a fresh 16-cycle period follows.

Source files
------------

// File: rtl/pwm_dimmer_if.sv
// Bundles the dimmer's run control, duty/prescale request and its PWM/strobe outputs.
interface pwm_dimmer_if #(
  parameter int N = 8,
  parameter int P = 16
) ();
  logic         ena;
  logic [N-1:0] duty;
  logic [P-1:0] prescale;
  logic         pwm;
  logic         period_start;
  logic         step;

  modport master (
    output ena, duty, prescale,
    input  pwm, period_start, step
  );

  modport slave (
    input  ena, duty, prescale,
    output pwm, period_start, step
  );
endinterface

// File: rtl/pwm_dimmer.sv
// Prescaled N-bit PWM generator; duty and prescale are sampled only at period
// boundaries, and a step strobe per completed period paces an upstream triangle source.
module pwm_dimmer #(
  parameter int N = 8,
  parameter int P = 16
) (
  input  logic         clk,
  input  logic         rst,
  pwm_dimmer_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]   state, state_nxt;
  logic [P-1:0] pre_cnt, pre_cnt_nxt;
  logic [P-1:0] pre_sh, pre_sh_nxt;
  logic [N-1:0] cnt, cnt_nxt;
  logic [N-1:0] duty_sh, duty_sh_nxt;
  logic         tick;
  logic         pwm_p1, pwm_nxt;
  logic         start_p1, start_nxt;
  logic         step_p1, step_nxt;

  always_comb begin
    state_nxt   = state;
    pre_cnt_nxt = pre_cnt;
    pre_sh_nxt  = pre_sh;
    cnt_nxt     = cnt;
    duty_sh_nxt = duty_sh;
    start_nxt   = 1'b0;
    step_nxt    = 1'b0;
    tick        = 1'b0;

    if (bus.ena) begin
      if (state == IDLE) begin
        // Arming: latch the first period's settings and start counting from zero.
        state_nxt   = RUN;
        duty_sh_nxt = bus.duty;
        pre_sh_nxt  = bus.prescale;
        pre_cnt_nxt = '0;
        cnt_nxt     = '0;
        start_nxt   = 1'b1;
      end else begin
        tick = (pre_cnt == pre_sh);
        if (tick) begin
          pre_cnt_nxt = '0;
          cnt_nxt     = cnt + 1'b1;
          if (cnt == '1) begin
            duty_sh_nxt = bus.duty;
            pre_sh_nxt  = bus.prescale;
            start_nxt   = 1'b1;
            step_nxt    = 1'b1;
          end
        end else begin
          pre_cnt_nxt = pre_cnt + 1'b1;
        end
      end
    end

    // Compare against next-cycle values so pwm lines up with the cnt it belongs to.
    pwm_nxt = bus.ena && (state_nxt == RUN) && (cnt_nxt < duty_sh_nxt);
  end

  // Stage p1: registered state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pre_cnt  <= '0;
      pre_sh   <= '0;
      cnt      <= '0;
      duty_sh  <= '0;
      pwm_p1   <= 1'b0;
      start_p1 <= 1'b0;
      step_p1  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pre_cnt  <= pre_cnt_nxt;
      pre_sh   <= pre_sh_nxt;
      cnt      <= cnt_nxt;
      duty_sh  <= duty_sh_nxt;
      pwm_p1   <= pwm_nxt;
      start_p1 <= start_nxt;
      step_p1  <= step_nxt;
    end
  end

  assign bus.pwm          = pwm_p1;
  assign bus.period_start = start_p1;
  assign bus.step         = step_p1;

endmodule

// File: tb/tb_pwm_dimmer.sv
// Randomized and directed bench for pwm_dimmer (N=4) against a period-position reference model.
module tb_pwm_dimmer;

  localparam int N  = 4;
  localparam int P  = 16;
  localparam int NC = 1 << N;

  logic clk;
  logic rst;

  pwm_dimmer_if #(.N(N), .P(P)) bus ();

  pwm_dimmer #(.N(N), .P(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: position t within the active period, latched duty/prescale.
  bit m_armed;
  int m_t, m_d, m_ps;
  int e_pwm, e_start, e_step;
  int n_hi, n_start, n_step;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d want=%0d", tag, $time, got, exp);
    end
  endtask

  function automatic int cur_k();
    return m_t / (m_ps + 1);
  endfunction

  task automatic model_step();
    if (rst) begin
      m_armed = 0; m_t = 0; m_d = 0; m_ps = 0;
      e_pwm = 0; e_start = 0; e_step = 0;
    end else if (!bus.ena) begin
      e_pwm = 0; e_start = 0; e_step = 0;
    end else if (!m_armed) begin
      m_armed = 1; m_t = 0;
      m_d = int'(bus.duty); m_ps = int'(bus.prescale);
      e_start = 1; e_step = 0;
      e_pwm = (0 < m_d) ? 1 : 0;
    end else begin
      m_t++;
      e_start = 0; e_step = 0;
      if (m_t == NC * (m_ps + 1)) begin
        m_t = 0;
        m_d = int'(bus.duty); m_ps = int'(bus.prescale);
        e_start = 1; e_step = 1;
      end
      e_pwm = (cur_k() < m_d) ? 1 : 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("pwm",   int'(bus.pwm),          e_pwm);
    chk("start", int'(bus.period_start), e_start);
    chk("step",  int'(bus.step),         e_step);
    n_hi    += int'(bus.pwm);
    n_start += int'(bus.period_start);
    n_step  += int'(bus.step);
  endtask

  task automatic run_to_cnt(input int k);
    int guard = 0;
    while (cur_k() != k && guard < 400) begin
      cyc();
      guard++;
    end
    chk("reach_cnt", cur_k(), k);
  endtask

  initial begin
    rst = 1'b1;
    bus.ena = 1'b0;
    bus.duty = '0;
    bus.prescale = '0;
    m_armed = 0; m_t = 0; m_d = 0; m_ps = 0;
    e_pwm = 0; e_start = 0; e_step = 0;
    n_hi = 0; n_start = 0; n_step = 0;

    // Reset, then idle with ena low: all outputs stay 0.
    repeat (2) cyc();
    rst = 1'b0;
    repeat (4) cyc();

    // duty 5, prescale 0: two full periods from arming.
    bus.duty = 4'd5;
    bus.ena = 1'b1;
    n_hi = 0; n_start = 0; n_step = 0;
    repeat (32) cyc();
    chk("hi_2per_d5", n_hi, 10);
    chk("start_2per", n_start, 2);
    chk("step_2per", n_step, 1);

    // prescale 2, duty 8: applied at the next boundary, then 48-cycle periods.
    bus.prescale = 16'd2;
    bus.duty = 4'd8;
    run_to_cnt(0);
    while (e_start == 0) cyc();
    n_hi = 0; n_step = 0;
    repeat (96) cyc();
    chk("hi_2per_d8p2", n_hi, 48);
    chk("step_2per_p2", n_step, 2);

    // Mid-period duty and prescale change are deferred.
    bus.prescale = 16'd0;
    bus.duty = 4'd5;
    repeat (100) cyc();
    run_to_cnt(3);
    bus.duty = 4'd12;
    bus.prescale = 16'd1;
    repeat (80) cyc();

    // Duty extremes.
    bus.prescale = 16'd0;
    bus.duty = 4'd0;
    repeat (70) cyc();
    bus.duty = 4'd15;
    repeat (70) cyc();

    // ena dropped for 7 cycles at cnt 9.
    bus.duty = 4'd5;
    repeat (20) cyc();
    run_to_cnt(9);
    bus.ena = 1'b0;
    n_hi = 0; n_start = 0; n_step = 0;
    repeat (7) cyc();
    chk("frozen_hi", n_hi, 0);
    chk("frozen_strobes", n_start + n_step, 0);
    bus.ena = 1'b1;
    repeat (40) cyc();

    // rst pulsed at cnt 10 with ena held high.
    run_to_cnt(10);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_step = 0;
    repeat (17) cyc();
    chk("rearm_step", n_step, 1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bus.ena = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) bus.duty = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) bus.prescale = 16'($urandom_range(0, 3));
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
